// File: rtl/hist_stream_if.sv
// Pixel input and histogram readout streams (valid/ready).
// Signal names are from the histogram engine's point of view.
interface hist_stream_if #(
  parameter int PIXEL_W = 8,
  parameter int COUNT_W = 24
);
  logic [PIXEL_W-1:0]         pix_i;
  logic                       pix_valid_i;
  logic                       pix_ready_o;
  logic [PIXEL_W+COUNT_W-1:0] hist_o;
  logic                       hist_valid_o;
  logic                       hist_ready_i;

  modport master (
    output pix_i, pix_valid_i, hist_ready_i,
    input  pix_ready_o, hist_o, hist_valid_o
  );

  modport slave (
    input  pix_i, pix_valid_i, hist_ready_i,
    output pix_ready_o, hist_o, hist_valid_o
  );
endinterface

// File: rtl/hist_stream_param.sv
// Streaming histogram with clear-on-read drain and saturating bins.
// Define HIST_CDF_EN to drain cumulative counts instead of raw counts.
module hist_stream_param #(
  parameter int          PIXEL_W    = 8,
  parameter int          COUNT_W    = 24,
  parameter int unsigned NUM_PIXELS = 76800
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  hist_stream_if.slave s_if,
  output logic         busy_o,
  output logic         done_o
);
  localparam int BINS = 2 ** PIXEL_W;
  localparam logic [COUNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    CLEAR, IDLE, ACCUM, DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [COUNT_W-1:0] mem_q [BINS];
  logic [COUNT_W-1:0] rd_q;
  logic [PIXEL_W-1:0] raddr;
  logic [PIXEL_W-1:0] waddr;
  logic [COUNT_W-1:0] wdata;
  logic               we;

  logic [PIXEL_W-1:0] cnt_q, cnt_d;
  logic [31:0]        pcnt_q, pcnt_d;
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic [PIXEL_W-1:0] b1_q, b1_d;
  logic [PIXEL_W-1:0] b2_q, b2_d;
  logic [COUNT_W-1:0] c2_q, c2_d;
  logic               done_q, done_d;

  logic               full, acc, xfer, last;
  logic [COUNT_W-1:0] op, inc, val;

  always_ff @(posedge clk_i) begin
    if (we) mem_q[waddr] <= wdata;
    rd_q <= mem_q[raddr];
  end

`ifdef HIST_CDF_EN
  logic [COUNT_W-1:0] sum_q, sum_d;
  logic [COUNT_W:0]   sum_w;

  assign sum_w = {1'b0, sum_q} + {1'b0, rd_q};
  assign val   = sum_w[COUNT_W] ? CMAX : sum_w[COUNT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  // Held at zero outside DRAIN so every drain starts from zero
  always_comb begin
    sum_d = sum_q;
    if (state_q != DRAIN) sum_d = '0;
    else if (xfer)        sum_d = val;
  end
`else
  assign val = rd_q;
`endif

  assign full = (pcnt_q == NUM_PIXELS);
  assign last = &cnt_q;

  assign s_if.pix_ready_o  = (state_q == ACCUM) && en_i && !full;
  assign acc               = s_if.pix_valid_i && s_if.pix_ready_o;
  assign s_if.hist_valid_o = (state_q == DRAIN);
  assign xfer              = s_if.hist_valid_o && s_if.hist_ready_i;
  assign s_if.hist_o       = s_if.hist_valid_o ? {cnt_q, val} : '0;

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

  // Previous write not yet visible in rd_q: take it from the bypass
  assign op  = (v2_q && (b2_q == b1_q)) ? c2_q : rd_q;
  assign inc = (op == CMAX) ? CMAX : op + COUNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      b1_q    <= '0;
      b2_q    <= '0;
      c2_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      c2_q    <= c2_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    v1_d    = acc;
    b1_d    = s_if.pix_i;
    v2_d    = v1_q;
    b2_d    = b1_q;
    c2_d    = inc;
    done_d  = 1'b0;
    raddr   = '0;
    waddr   = cnt_q;
    wdata   = '0;
    we      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        cnt_d = cnt_q + PIXEL_W'(1);
        if (last) state_d = IDLE;
      end
      IDLE: begin
        if (en_i) begin
          state_d = ACCUM;
          pcnt_d  = '0;
        end
      end
      ACCUM: begin
        if (!full) raddr = s_if.pix_i;
        if (acc)   pcnt_d = pcnt_q + 32'd1;
        we    = v1_q;
        waddr = b1_q;
        wdata = inc;
        // raddr parks on bin 0 once full, priming the first drain word
        if (full && !v1_q) state_d = DRAIN;
      end
      DRAIN: begin
        raddr = xfer ? cnt_q + PIXEL_W'(1) : cnt_q;
        we    = xfer;
        if (xfer) begin
          cnt_d = cnt_q + PIXEL_W'(1);
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_hist_stream_param.sv
// Directed bench for hist_stream_param with a histogram scoreboard.
// Covers 24-bit and saturating 4-bit instances, raw or CDF drain.
module tb_hist_stream_param;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sel;
  logic [7:0] pix;
  logic       pvalid, hr;

  logic        prdy, hv, done, busy;
  logic [31:0] hist;
  logic        done0, done1, busy0, busy1;

  int vecs = 0;
  int errs = 0;
  int cnt_m [256];
  int cmax;
  logic [7:0]  pq [$];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  hist_stream_if #(.PIXEL_W(8), .COUNT_W(24)) if0 ();
  hist_stream_if #(.PIXEL_W(8), .COUNT_W(4))  if1 ();

  assign if0.pix_i        = pix;
  assign if0.pix_valid_i  = pvalid;
  assign if0.hist_ready_i = hr;
  assign if1.pix_i        = pix;
  assign if1.pix_valid_i  = pvalid;
  assign if1.hist_ready_i = hr;

  hist_stream_param #(
    .PIXEL_W(8), .COUNT_W(24), .NUM_PIXELS(16)
  ) dut0 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (en & ~sel),
    .s_if  (if0),
    .busy_o(busy0),
    .done_o(done0)
  );

  hist_stream_param #(
    .PIXEL_W(8), .COUNT_W(4), .NUM_PIXELS(20)
  ) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (en & sel),
    .s_if  (if1),
    .busy_o(busy1),
    .done_o(done1)
  );

  assign prdy = sel ? if1.pix_ready_o  : if0.pix_ready_o;
  assign hv   = sel ? if1.hist_valid_o : if0.hist_valid_o;
  assign hist = sel ? 32'(if1.hist_o)  : if0.hist_o;
  assign done = sel ? done1 : done0;
  assign busy = sel ? busy1 : busy0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int gap_pct, input int off_at);
    int n   = 0;
    int cyc = 0;
    en = 1'b1;
    while (pq.size() > 0 && cyc < 2000) begin
      if (n == off_at) begin
        en     = 1'b0;
        pvalid = 1'b1;
        pix    = pq[0];
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", {31'b0, prdy}, 32'd0);
          @(posedge clk); #1;
        end
        en     = 1'b1;
        off_at = -1;
      end
      pix    = pq[0];
      pvalid = ($urandom_range(99) >= gap_pct);
      @(negedge clk);
      if (pvalid && prdy) begin
        void'(pq.pop_front());
        n++;
        if (cnt_m[pix] < cmax) cnt_m[pix]++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (pq.size() > 0) begin
      chk("feed_timeout", pq.size(), 32'd0);
      pq.delete();
    end
    pvalid = 1'b0;
  endtask

  task automatic extra_ignored();
    pvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_after_last", {31'b0, prdy}, 32'd0);
      @(posedge clk); #1;
    end
    pvalid = 1'b0;
  endtask

  task automatic drain(input int bp_pct);
    int          sum = 0;
    int          v, cyc;
    logic        hold;
    logic [31:0] held, e;
    for (int b = 0; b < 256; b++) begin
`ifdef HIST_CDF_EN
      sum = sum + cnt_m[b];
      if (sum > cmax) sum = cmax;
      v = sum;
`else
      v = cnt_m[b];
`endif
      e = sel ? ((b << 4) | v) : ((b << 24) | v);
      exp_q.push_back(e);
      cnt_m[b] = 0;
    end
    hold = 1'b0;
    held = '0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      hr = ($urandom_range(99) >= bp_pct);
      @(negedge clk);
      if (hold) chk("hold_stable", hist, held);
      if (hv && hr) begin
        e = exp_q.pop_front();
        chk("drain_word", hist, e);
        hold = 1'b0;
      end else begin
        hold = hv;
        held = hist;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    hr = 1'b0;
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("valid_after", {31'b0, hv}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_single", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic clear_len();
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_cycles", n, 32'd256);
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_ready"}, {31'b0, prdy}, 32'd0);
    chk({tag, "_valid"}, {31'b0, hv}, 32'd0);
    chk({tag, "_hist"}, hist, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    sel    = 1'b0;
    pix    = '0;
    pvalid = 1'b0;
    hr     = 1'b0;
    cmax   = 24'hFFFFFF;
    for (int b = 0; b < 256; b++) cnt_m[b] = 0;

    @(posedge clk); #1;
    reset_outs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_len();

    // Full-rate run of one value exercises the bypass
    for (int i = 0; i < 16; i++) pq.push_back(8'h2A);
    feed(0, -1);
    extra_ignored();
    en = 1'b0;
    drain(0);

    // Alternating bins, input gaps, enable dropped mid-frame
    for (int i = 0; i < 16; i++) pq.push_back(8'(i % 2));
    feed(30, 6);
    extra_ignored();
    en = 1'b0;
    drain(50);

    // Earlier bins must have been cleared by the drain
    for (int i = 0; i < 16; i++) pq.push_back(8'hFF);
    feed(0, -1);
    en = 1'b0;
    drain(40);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) pq.push_back(8'h55);
    feed(0, -1);
    rst_n = 1'b0;
    #1;
    reset_outs("midrst");
    for (int b = 0; b < 256; b++) cnt_m[b] = 0;
    en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_len();
    for (int i = 0; i < 16; i++)
      pq.push_back(8'($urandom_range(3) + 16));
    feed(20, -1);
    extra_ignored();
    en = 1'b0;
    drain(30);

    // 4-bit counters saturate at 15
    sel  = 1'b1;
    cmax = 15;
    for (int i = 0; i < 20; i++) pq.push_back(8'h07);
    feed(0, -1);
    extra_ignored();
    en = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
